// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared widths, opcode constants, entry/broadcast/issue types
// and the operand snoop helper used by the ALU reservation station.
//   OP_WID / FUNCT3_WID / ROB_POS_WID : instruction and ROB tag widths
//   OPCODE_*                          : ALU-class opcodes
//   src_t / bcast_t / rs_entry_t / issue_t : storage and bus records
//   src_snoop()                       : capture a broadcast into a pending source
package alu_rs_pkg;

    localparam int OP_WID      = 7;
    localparam int FUNCT3_WID  = 3;
    localparam int ROB_POS_WID = 4;

    localparam logic [OP_WID-1:0] OPCODE_ARITH  = 7'b0110011;
    localparam logic [OP_WID-1:0] OPCODE_ARITHI = 7'b0010011;
    localparam logic [OP_WID-1:0] OPCODE_BR     = 7'b1100011;
    localparam logic [OP_WID-1:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [OP_WID-1:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [OP_WID-1:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [OP_WID-1:0] OPCODE_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic                   has_q;
        logic [ROB_POS_WID-1:0] q;
        logic [31:0]            v;
    } src_t;

    typedef struct packed {
        logic                   valid;
        logic [ROB_POS_WID-1:0] tag;
        logic [31:0]            val;
    } bcast_t;

    typedef struct packed {
        logic [OP_WID-1:0]      opcode;
        logic [FUNCT3_WID-1:0]  funct3;
        logic                   funct7;
        logic [31:0]            imm;
        logic [31:0]            pc;
        logic [ROB_POS_WID-1:0] rob_pos;
        src_t                   src1;
        src_t                   src2;
    } rs_entry_t;

    typedef struct packed {
        logic [OP_WID-1:0]      opcode;
        logic [FUNCT3_WID-1:0]  funct3;
        logic                   funct7;
        logic [31:0]            val1;
        logic [31:0]            val2;
        logic [31:0]            imm;
        logic [31:0]            pc;
        logic [ROB_POS_WID-1:0] rob_pos;
    } issue_t;

    // ALU broadcast has priority if both buses carry the same tag.
    function automatic src_t src_snoop(input src_t s, input bcast_t alu_bc, input bcast_t lsb_bc);
        src_t r;
        r = s;
        if (s.has_q) begin
            if (alu_bc.valid && (alu_bc.tag == s.q)) begin
                r.has_q = 1'b0;
                r.v     = alu_bc.val;
            end else if (lsb_bc.valid && (lsb_bc.tag == s.q)) begin
                r.has_q = 1'b0;
                r.v     = lsb_bc.val;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, result-broadcast and issue signals of the ALU
// reservation station.
//   master : dispatcher/broadcast side (drives disp_*, *_result*, reads issue)
//   slave  : reservation station side
interface alu_rs_if import alu_rs_pkg::*; ();

    logic                   disp_en;
    logic [OP_WID-1:0]      disp_opcode;
    logic [FUNCT3_WID-1:0]  disp_funct3;
    logic                   disp_funct7;
    logic                   disp_has_q1;
    logic                   disp_has_q2;
    logic [ROB_POS_WID-1:0] disp_q1;
    logic [ROB_POS_WID-1:0] disp_q2;
    logic [31:0]            disp_v1;
    logic [31:0]            disp_v2;
    logic [31:0]            disp_imm;
    logic [31:0]            disp_pc;
    logic [ROB_POS_WID-1:0] disp_rob_pos;

    logic                   alu_result;
    logic [ROB_POS_WID-1:0] alu_result_rob_pos;
    logic [31:0]            alu_result_val;
    logic                   lsb_result;
    logic [ROB_POS_WID-1:0] lsb_result_rob_pos;
    logic [31:0]            lsb_result_val;

    logic                   rs_full;
    logic                   alu_en;
    logic [OP_WID-1:0]      opcode;
    logic [FUNCT3_WID-1:0]  funct3;
    logic                   funct7;
    logic [31:0]            val1;
    logic [31:0]            val2;
    logic [31:0]            imm;
    logic [31:0]            pc;
    logic [ROB_POS_WID-1:0] rob_pos;

    modport master (
        output disp_en, disp_opcode, disp_funct3, disp_funct7,
               disp_has_q1, disp_has_q2, disp_q1, disp_q2, disp_v1, disp_v2,
               disp_imm, disp_pc, disp_rob_pos,
               alu_result, alu_result_rob_pos, alu_result_val,
               lsb_result, lsb_result_rob_pos, lsb_result_val,
        input  rs_full, alu_en, opcode, funct3, funct7, val1, val2, imm, pc, rob_pos
    );

    modport slave (
        input  disp_en, disp_opcode, disp_funct3, disp_funct7,
               disp_has_q1, disp_has_q2, disp_q1, disp_q2, disp_v1, disp_v2,
               disp_imm, disp_pc, disp_rob_pos,
               alu_result, alu_result_rob_pos, alu_result_val,
               lsb_result, lsb_result_rob_pos, lsb_result_val,
        output rs_full, alu_en, opcode, funct3, funct7, val1, val2, imm, pc, rob_pos
    );

endinterface

// File: rtl/alu_rs_select.sv
// rs_select: priority finder; reports whether any req bit is set and the
// lowest set index.
//   req   : request vector
//   found : at least one bit set
//   idx   : lowest set index (0 when nothing is set)
module rs_select #(
    parameter  int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: reservation station and issue scheduler for the integer ALU.
// Buffers dispatched ALU-class instructions until both operands are known,
// snoops the ALU and LSB result broadcasts, and issues one ready entry per
// cycle onto registered issue outputs.
//   clk, rst_n  : clock, asynchronous active-low reset
//   rdy         : global enable, low freezes everything
//   rollback    : flush all entries at the next edge
//   bus (slave) : dispatch, broadcasts, rs_full and issue outputs
// Build option: ALU_RS_AGE_SELECT_EN selects the oldest ready entry instead
// of the lowest-index one and adds per-entry age counters.
module alu_rs import alu_rs_pkg::*; #(
    parameter int RS_SIZE = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rdy,
    input  logic     rollback,
    alu_rs_if.slave  bus
);

    localparam int RS_IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]  busy_q, busy_d;
    rs_entry_t           ent_q [RS_SIZE];
    rs_entry_t           ent_d [RS_SIZE];
    issue_t              iss_q, iss_d;
    logic                alu_en_q, alu_en_d;

    bcast_t              alu_bc, lsb_bc;
    logic [RS_SIZE-1:0]  free_vec, ready_vec;
    logic                free_found, sel_found, disp_fire;
    logic [RS_IDX_W-1:0] free_idx, sel_idx;
    rs_entry_t           disp_ent;

    assign alu_bc = '{valid: bus.alu_result, tag: bus.alu_result_rob_pos, val: bus.alu_result_val};
    assign lsb_bc = '{valid: bus.lsb_result, tag: bus.lsb_result_rob_pos, val: bus.lsb_result_val};

    // Both vectors use start-of-cycle state, so a slot freed by issue is not
    // re-allocated and a freshly woken entry is not selected until next cycle.
    assign free_vec = ~busy_q;
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = busy_q[i] & ~ent_q[i].src1.has_q & ~ent_q[i].src2.has_q;
        end
    end

    rs_select #(.N(RS_SIZE)) u_free_sel (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    assign disp_fire = rdy & ~rollback & bus.disp_en & free_found;

    always_comb begin
        disp_ent.opcode  = bus.disp_opcode;
        disp_ent.funct3  = bus.disp_funct3;
        disp_ent.funct7  = bus.disp_funct7;
        disp_ent.imm     = bus.disp_imm;
        disp_ent.pc      = bus.disp_pc;
        disp_ent.rob_pos = bus.disp_rob_pos;
        disp_ent.src1    = src_snoop('{has_q: bus.disp_has_q1, q: bus.disp_q1, v: bus.disp_v1},
                                     alu_bc, lsb_bc);
        disp_ent.src2    = src_snoop('{has_q: bus.disp_has_q2, q: bus.disp_q2, v: bus.disp_v2},
                                     alu_bc, lsb_bc);
    end

`ifdef ALU_RS_AGE_SELECT_EN
    // age = number of younger busy entries; the oldest ready entry has the
    // largest age among ready entries (ages of busy entries are distinct).
    logic [RS_IDX_W-1:0] age_q [RS_SIZE];
    logic [RS_IDX_W-1:0] age_d [RS_SIZE];
    logic [RS_IDX_W-1:0] best_age;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready_vec[i] && (!sel_found || (age_q[i] > best_age))) begin
                sel_found = 1'b1;
                sel_idx   = RS_IDX_W'(i);
                best_age  = age_q[i];
            end
        end
    end

    always_comb begin
        age_d = age_q;
        if (rdy) begin
            if (rollback) begin
                for (int i = 0; i < RS_SIZE; i++) age_d[i] = '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i]) begin
                        age_d[i] = age_q[i] + RS_IDX_W'(disp_fire)
                                 - RS_IDX_W'(sel_found && (age_q[i] > best_age));
                    end
                end
                if (disp_fire) age_d[free_idx] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_SIZE; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) age_q[i] <= age_d[i];
        end
    end
`else
    rs_select #(.N(RS_SIZE)) u_ready_sel (
        .req   (ready_vec),
        .found (sel_found),
        .idx   (sel_idx)
    );
`endif

    always_comb begin
        busy_d   = busy_q;
        ent_d    = ent_q;
        iss_d    = iss_q;
        alu_en_d = alu_en_q;
        if (rdy) begin
            alu_en_d = 1'b0;
            if (rollback) begin
                busy_d = '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    ent_d[i].src1 = src_snoop(ent_q[i].src1, alu_bc, lsb_bc);
                    ent_d[i].src2 = src_snoop(ent_q[i].src2, alu_bc, lsb_bc);
                end
                if (sel_found) begin
                    busy_d[sel_idx] = 1'b0;
                    alu_en_d        = 1'b1;
                    iss_d.opcode    = ent_q[sel_idx].opcode;
                    iss_d.funct3    = ent_q[sel_idx].funct3;
                    iss_d.funct7    = ent_q[sel_idx].funct7;
                    iss_d.val1      = ent_q[sel_idx].src1.v;
                    iss_d.val2      = ent_q[sel_idx].src2.v;
                    iss_d.imm       = ent_q[sel_idx].imm;
                    iss_d.pc        = ent_q[sel_idx].pc;
                    iss_d.rob_pos   = ent_q[sel_idx].rob_pos;
                end
                if (disp_fire) begin
                    busy_d[free_idx] = 1'b1;
                    ent_d[free_idx]  = disp_ent;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            iss_q    <= '0;
            alu_en_q <= 1'b0;
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
        end else begin
            busy_q   <= busy_d;
            iss_q    <= iss_d;
            alu_en_q <= alu_en_d;
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
        end
    end

    assign bus.rs_full = &busy_q;
    assign bus.alu_en  = alu_en_q;
    assign bus.opcode  = iss_q.opcode;
    assign bus.funct3  = iss_q.funct3;
    assign bus.funct7  = iss_q.funct7;
    assign bus.val1    = iss_q.val1;
    assign bus.val2    = iss_q.val2;
    assign bus.imm     = iss_q.imm;
    assign bus.pc      = iss_q.pc;
    assign bus.rob_pos = iss_q.rob_pos;

endmodule
